// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/ack and ID-side flow control.
// master = fetch unit, slave = memory / ID / EX side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_ir;
    logic [31:0] id_pc;
    logic [31:0] id_pc_next;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        input  redirect, redirect_pc, id_stall,
        output id_valid, id_ir, id_pc, id_pc_next
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        output redirect, redirect_pc, id_stall,
        input  id_valid, id_ir, id_pc, id_pc_next
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with PC, one-outstanding imem fetch and instruction queue.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic         clk,
    input  logic         clear_n,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_bubbles
`endif
);
    localparam int unsigned PW     = (QDEPTH == 4) ? 2 : 1;
    localparam logic [2:0]  DEPTH  = 3'(QDEPTH);
    localparam logic [31:0] PC_RST = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   pc_q, pc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [PW-1:0] hd_q, hd_d;
    logic [PW-1:0] tl_q, tl_d;
    logic [31:0]   ir_q  [QDEPTH];
    logic [31:0]   ipc_q [QDEPTH];

    logic ack, busy, slot, push, pop, issue, vld;

    assign ack  = req_q & bus.imem_ack;
    assign busy = state_q != IDLE;
    assign slot = ~busy | ack;
    assign vld  = cnt_q != 3'd0;
    assign push = ack & (state_q == REQ) & ~bus.redirect;
    assign pop  = vld & ~bus.id_stall & ~bus.redirect;

    always_comb begin
        cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
        hd_d  = hd_q + PW'(pop);
        tl_d  = tl_q + PW'(push);
        if (bus.redirect) begin
            cnt_d = '0;
            hd_d  = '0;
            tl_d  = '0;
        end
    end

    // Credit uses post-edge occupancy, so a returning word always has a slot.
    assign issue = slot & ~bus.redirect & (cnt_d < DEPTH);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.redirect) begin
            state_d = (busy & ~ack) ? DROP : IDLE;
        end else if (issue) begin
            state_d = REQ;
        end else if (slot) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        pc_d   = pc_q;
        if (bus.redirect) begin
            pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            if (slot) req_d = 1'b0;
        end else if (issue) begin
            req_d  = 1'b1;
            addr_d = pc_q;
            pc_d   = pc_q + 32'd4;
        end else if (slot) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            req_q  <= 1'b0;
            addr_q <= PC_RST;
            pc_q   <= PC_RST;
            cnt_q  <= '0;
            hd_q   <= '0;
            tl_q   <= '0;
        end else begin
            req_q  <= req_d;
            addr_q <= addr_d;
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            hd_q   <= hd_d;
            tl_q   <= tl_d;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                ir_q[i]  <= '0;
                ipc_q[i] <= '0;
            end
        end else if (push) begin
            ir_q[tl_q]  <= bus.imem_data;
            ipc_q[tl_q] <= addr_q;
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.id_valid   = vld;
    assign bus.id_ir      = vld ? ir_q[hd_q] : '0;
    assign bus.id_pc      = vld ? ipc_q[hd_q] : '0;
    assign bus.id_pc_next = (vld ? ipc_q[hd_q] : '0) + 32'd4;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fet_q, bub_q;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            fet_q <= '0;
            bub_q <= '0;
        end else begin
            if (pop) fet_q <= fet_q + 32'd1;
            if (!vld && !bus.id_stall) bub_q <= bub_q + 32'd1;
        end
    end

    assign perf_fetched = fet_q;
    assign perf_bubbles = bub_q;
`endif
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
IF stage feeding the ID instruction register. It owns the PC and issues one-outstanding word requests to instruction memory over a req/ack handshake. Returned words are buffered with their PC in a small instruction queue, and presented to ID with valid/stall flow control. It accepts a redirect (branch/jump target) from EX that flushes all younger work.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset
QDEPTH, 2, instruction queue entries; legal values 2 or 4

Ports:
clk  in  1  master clock, all state on posedge
clear_n  in  1  asynchronous active-low reset
imem_req  out  1  request to instruction memory, registered
imem_addr  out  32  word address of request, registered, stable while imem_req=1
imem_ack  in  1  memory returns imem_data this cycle; meaningful only while imem_req=1
imem_data  in  32  instruction word
redirect  in  1  EX branch/jump taken, one-cycle pulse
redirect_pc  in  32  new fetch target, valid with redirect
id_stall  in  1  ID cannot accept this cycle
id_valid  out  1  id_ir/id_pc hold a real instruction
id_ir  out  32  queue head instruction; 32'h00000000 (nop) when id_valid=0
id_pc  out  32  PC of id_ir; 0 when id_valid=0
id_pc_next  out  32  id_pc + 4, mod 2^32

Behaviour:
- Reset (clear_n=0, async): imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, queue empty, count=0, state=IDLE, id_valid=0, id_ir=0, id_pc=0.
- Outstanding requests abandoned on reset; the memory model must tolerate a dropped request.
- States:
  - IDLE: no outstanding request.
  - REQ: request outstanding, response will be kept.
  - DROP: request outstanding, response will be discarded.
- Issue rule: in IDLE, or in REQ on the ack edge, set imem_req=1 and imem_addr=fetch_pc when (count after this edge) + 1 <= QDEPTH and no redirect this cycle. Then fetch_pc += 4 (wraps at 2^32). Otherwise imem_req=0, state=IDLE.
- The credit rule guarantees a returning word always has a free slot.
- Ack handling: on a posedge with imem_req=1 and imem_ack=1:
  - REQ: push {imem_addr, imem_data}.
  - DROP: discard, then apply the issue rule.
- Zero-wait memory sustains one instruction per cycle.
- First request is asserted at the first posedge after clear_n rises. The first id_valid=1 appears one edge after the ack edge.
- Pop: on a posedge with id_valid=1 and id_stall=0, the head is removed.
- Push and pop on the same edge leave count unchanged. Head ordering is strict FIFO.
- id_* outputs are combinational from the queue head.
- Stall: id_stall=1 holds id_ir/id_pc/id_valid constant. Fetch continues until the credit rule blocks.
- Redirect (priority over push, pop, and issue):
  - Queue flushed (count=0); fetch_pc=redirect_pc.
  - If a request is outstanding and not acked this cycle: state=DROP, imem_req stays 1 with the old address until ack.
  - If acked this cycle, or IDLE: the next edge issues redirect_pc with state=REQ.
  - id_valid=0 on the cycle after the redirect edge.
- Redirect while in DROP: update fetch_pc only; stay in DROP.
- id_valid=1 and id_stall=0 on the same cycle as redirect: the head is not counted as consumed by ID. EX squashes it.
- imem_addr bits [1:0] are always 00. redirect_pc[1:0] is ignored (forced 00).

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32), count of pops, and perf_bubbles (32), count of cycles with id_valid=0 and id_stall=0. Both are reset to 0 and wrap.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Zero-wait memory (ack=req), mem[0..3]=8C010004,8C020008,0,0, no stall -> id_pc 0,4,8,C on consecutive cycles after the first; id_ir matches mem; id_pc_next 4,8,C,10.
- Memory ack after 3 cycles, QDEPTH=2 -> id_valid pulses once per 4 cycles; imem_addr constant while imem_req=1.
- id_stall=1 for 6 cycles with zero-wait memory -> id_pc holds; imem_req drops after 2 words buffered (count=2); on release, 3 instructions leave in order with no gap.
- Redirect to 0x20 while a request for 0x8 is outstanding (ack 2 cycles later) -> 0x8 data is never presented; next id_pc=0x20; no id_valid between.
- Redirect and ack on the same edge; fetch_pc wrap: redirect_pc=0xFFFFFFFC -> next id_pc=0xFFFFFFFC, following request address 0x00000000.
- clear_n low mid-request -> imem_req=0, id_valid=0 immediately; after release, the first request goes to RESET_PC; with FETCH_PERF_CNT_EN, both counters read 0.
